// File: rtl/fifo_rx_frame.sv
// Store-and-forward RX frame FIFO: bytes become readable only after a good wr_last commits the frame;
// errored or overflowing frames are discarded by rewinding the write pointer to the last commit point.
module fifo_rx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  input  logic                  wr_err,
  output logic                  wr_full,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  input  logic                  rd_ready,
  output logic                  drop_pulse,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]          PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]          DEPTH_P = {1'b1, {AW{1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH:0]  r_mem [FIFO_DEPTH];
  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_commit_ptr;
  logic [AW:0]          r_rd_ptr;
  logic                 r_ovf;
  logic                 r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                 r_rd_last;
  logic                 r_drop_pulse;
  logic [CNT_WIDTH-1:0] r_drop_count;

  logic w_full;
  logic w_present;
  logic w_store;
  logic w_drop;
  logic w_load;

  // Free space is judged on the pre-edge read pointer, so a same-cycle read does not free a slot.
  assign w_full    = ((r_wr_ptr - r_rd_ptr) == DEPTH_P);
  assign w_present = (r_commit_ptr != r_rd_ptr);
  assign w_store   = wr_valid && !w_full && !r_ovf;
  assign w_drop    = wr_valid && wr_last && (wr_err || !w_store);
  assign w_load    = w_present && (!r_rd_valid || rd_ready);

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {wr_last, wr_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_ovf        <= 1'b0;
      r_drop_pulse <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_drop_pulse <= w_drop;
      if (w_drop) begin
        r_wr_ptr <= r_commit_ptr;
        r_ovf    <= 1'b0;
        if (r_drop_count != '1) begin
          r_drop_count <= r_drop_count + CNT_ONE;
        end
      end else if (w_store) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (wr_last) begin
          r_commit_ptr <= r_wr_ptr + PTR_ONE;
        end
      end else if (wr_valid) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_last  <= 1'b0;
    end else if (w_load) begin
      {r_rd_last, r_rd_data} <= r_mem[r_rd_ptr[AW-1:0]];
      r_rd_ptr   <= r_rd_ptr + PTR_ONE;
      r_rd_valid <= 1'b1;
    end else if (rd_ready) begin
      r_rd_valid <= 1'b0;
    end
  end

  assign wr_full    = w_full;
  assign rd_valid   = r_rd_valid;
  assign rd_data    = r_rd_data;
  assign rd_last    = r_rd_last;
  assign drop_pulse = r_drop_pulse;
  assign drop_count = r_drop_count;

endmodule
